// File: rtl/myfpga_pkg.sv
// Shared types for the programmable counter/timer: run modes and FSM states.
package myfpga_pkg;

  // Run mode selected by i_Mode; MODE_RSVD decodes exactly like MODE_FREE.
  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_RELOAD  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  // Counter control state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the mode stops the counter at its terminal value.
  function automatic logic mode_is_oneshot(input mode_t mode);
    return (mode == MODE_ONESHOT);
  endfunction

  // True when the mode reloads i_LoadValue at its terminal value.
  function automatic logic mode_is_reload(input mode_t mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/prog_counter_timer_chk.sv
// Property checker bound into prog_counter_timer: reset and load outcomes.
module prog_counter_timer_chk #(
  parameter int WIDTH = 8
) (
  input logic             i_Clock,
  input logic             i_Reset,
  input logic             i_Load,
  input logic [WIDTH-1:0] i_LoadValue,
  input logic [WIDTH-1:0] i_Count,
  input logic             i_Terminal,
  input logic             i_Running
);

  // A reset cycle always lands in the cleared, stopped state.
  a_reset_clears: assert property (@(posedge i_Clock)
    i_Reset |=> (i_Count == {WIDTH{1'b0}}) && !i_Terminal && !i_Running);

  // A load never produces a terminal pulse and always takes the load value.
  a_load_wins: assert property (@(posedge i_Clock)
    (i_Load && !i_Reset) |=> !i_Terminal && (i_Count == $past(i_LoadValue)));

endmodule

// File: rtl/tick_prescaler.sv
// Prescaler for prog_counter_timer: emits a tick every i_Prescale+1 running
// cycles. The phase register is held while not running, so a pause/resume
// keeps the phase; i_Clear restarts the phase (used by a load).
module tick_prescaler
  import myfpga_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Run,
  input  logic                      i_Clear,
  input  logic [PRESCALE_WIDTH-1:0] i_Prescale,
  output logic                      o_Tick
);

  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      w_match;

  // The divisor is compared live, so lowering i_Prescale below r_pre simply
  // lets r_pre wrap around before the next match.
  assign w_match = (r_pre == i_Prescale);
  assign o_Tick  = i_Run && w_match;

  // Phase register: cleared on reset/clear, advances only while running.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_pre <= {PRESCALE_WIDTH{1'b0}};
    end else if (i_Clear) begin
      r_pre <= {PRESCALE_WIDTH{1'b0}};
    end else if (i_Run) begin
      if (w_match) begin
        r_pre <= {PRESCALE_WIDTH{1'b0}};
      end else begin
        r_pre <= r_pre + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      r_pre <= r_pre;
    end
  end

endmodule

// File: rtl/prog_counter_timer.sv
// Programmable counter/timer: prescaled up/down counter with FREE, ONESHOT
// and RELOAD modes, a registered terminal pulse and a PWM compare output.
// With defaults (prescale 0, FREE, up, enable high) o_Msb is a divide-by-256
// square wave like the original free-running counter.
module prog_counter_timer
  import myfpga_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic                      i_Load,
  input  logic [WIDTH-1:0]          i_LoadValue,
  input  logic [PRESCALE_WIDTH-1:0] i_Prescale,
  input  logic [1:0]                i_Mode,
  input  logic                      i_Down,
  input  logic [WIDTH-1:0]          i_Compare,
  output logic [WIDTH-1:0]          o_Count,
  output logic                      o_Msb,
  output logic                      o_Terminal,
  output logic                      o_Pwm,
  output logic                      o_Running
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_terminal;
  logic             w_terminal_next;
  logic             r_running;

  mode_t            w_mode;
  logic             w_run;
  logic             w_tick;
  logic [WIDTH-1:0] w_terminal_value;
  logic             w_at_terminal;
  logic [WIDTH-1:0] w_count_step;

  // Mode and direction are read live, so a change applies at the next tick.
  assign w_mode           = mode_t'(i_Mode);
  assign w_terminal_value = i_Down ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
  assign w_at_terminal    = (r_count == w_terminal_value);
  assign w_count_step     = i_Down ? (r_count - {{(WIDTH-1){1'b0}}, 1'b1})
                                   : (r_count + {{(WIDTH-1){1'b0}}, 1'b1});

  // The prescaler only advances in RUN with enable high; a pause leaves its
  // phase untouched.
  assign w_run = (r_state == ST_RUN) && i_Enable;

  tick_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Run     (w_run),
    .i_Clear   (i_Load),
    .i_Prescale(i_Prescale),
    .o_Tick    (w_tick)
  );

  // Next-state, next-count and terminal-pulse decode; a load overrides
  // everything, including a coincident tick.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_terminal_next = 1'b0;
    if (i_Load) begin
      w_count_next = i_LoadValue;
      w_state_next = i_Enable ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_Enable) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!i_Enable) begin
            w_state_next = ST_IDLE;
          end else if (w_tick) begin
            if (w_at_terminal) begin
              w_terminal_next = 1'b1;
              if (mode_is_oneshot(w_mode)) begin
                w_count_next = r_count;
                w_state_next = ST_DONE;
              end else if (mode_is_reload(w_mode)) begin
                w_count_next = i_LoadValue;
                w_state_next = ST_RUN;
              end else begin
                // FREE and the reserved mode wrap modulo 2^WIDTH.
                w_count_next = w_count_step;
                w_state_next = ST_RUN;
              end
            end else begin
              w_count_next = w_count_step;
              w_state_next = ST_RUN;
            end
          end else begin
            w_state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          // Only a load (handled above) or reset leaves DONE.
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, count and output registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= {WIDTH{1'b0}};
      r_terminal <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_terminal <= w_terminal_next;
      r_running  <= (w_state_next == ST_RUN);
    end
  end

  assign o_Count    = r_count;
  assign o_Msb      = r_count[WIDTH-1];
  assign o_Terminal = r_terminal;
  assign o_Running  = r_running;
  assign o_Pwm      = (r_count < i_Compare);

  prog_counter_timer_chk #(
    .WIDTH(WIDTH)
  ) u_chk (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Load     (i_Load),
    .i_LoadValue(i_LoadValue),
    .i_Count    (r_count),
    .i_Terminal (r_terminal),
    .i_Running  (r_running)
  );

endmodule

// File: tb/tb_prog_counter_timer.sv
// Directed self-checking bench for prog_counter_timer (default parameters).
module tb_prog_counter_timer;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             i_Clock = 1'b0;
  logic             i_Reset;
  logic             i_Enable;
  logic             i_Load;
  logic [WIDTH-1:0] i_LoadValue;
  logic [PW-1:0]    i_Prescale;
  logic [1:0]       i_Mode;
  logic             i_Down;
  logic [WIDTH-1:0] i_Compare;
  logic [WIDTH-1:0] o_Count;
  logic             o_Msb;
  logic             o_Terminal;
  logic             o_Pwm;
  logic             o_Running;

  int n_checks = 0;
  int n_pass   = 0;

  prog_counter_timer #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Load(i_Load),
    .i_LoadValue(i_LoadValue), .i_Prescale(i_Prescale), .i_Mode(i_Mode),
    .i_Down(i_Down), .i_Compare(i_Compare), .o_Count(o_Count), .o_Msb(o_Msb),
    .o_Terminal(o_Terminal), .o_Pwm(o_Pwm), .o_Running(o_Running)
  );

  always #5 i_Clock = ~i_Clock;

  // Advance one edge and settle; inputs changed afterwards apply at the next edge.
  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  // Hold reset for one edge, then release it with the current settings.
  task automatic do_reset();
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Enable = 1'b1; i_Load = 1'b0; i_LoadValue = 8'd77;
    i_Prescale = 4'd0; i_Mode = 2'd0; i_Down = 1'b0; i_Compare = 8'd5;
    step(); step();
    n_checks++; if (o_Count !== 8'd0) $display("FAIL reset_count got %0d want 0", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b0) $display("FAIL reset_terminal got %b want 0", o_Terminal); else n_pass++;
    n_checks++; if (o_Running !== 1'b0) $display("FAIL reset_running got %b want 0", o_Running); else n_pass++;
    n_checks++; if (o_Msb !== 1'b0) $display("FAIL reset_msb got %b want 0", o_Msb); else n_pass++;
    n_checks++; if (o_Pwm !== 1'b1) $display("FAIL reset_pwm_cmp5 got %b want 1", o_Pwm); else n_pass++;
    i_Compare = 8'd0;
    #1;
    n_checks++; if (o_Pwm !== 1'b0) $display("FAIL reset_pwm_cmp0 got %b want 0", o_Pwm); else n_pass++;
  endtask

  task automatic test_free_run();
    logic [7:0] e;
    i_Enable = 1'b1; i_Mode = 2'd0; i_Down = 1'b0; i_Prescale = 4'd0;
    do_reset();
    step();
    n_checks++; if (o_Running !== 1'b1) $display("FAIL free_running got %b want 1", o_Running); else n_pass++;
    n_checks++; if (o_Count !== 8'd0) $display("FAIL free_first got %0d want 0", o_Count); else n_pass++;
    for (int k = 1; k <= 600; k++) begin
      step();
      e = 8'(k);
      n_checks++; if (o_Count !== e) $display("FAIL free_count k=%0d got %0d want %0d", k, o_Count, e); else n_pass++;
      n_checks++; if (o_Msb !== e[7]) $display("FAIL free_msb k=%0d got %b want %b", k, o_Msb, e[7]); else n_pass++;
      n_checks++;
      if (o_Terminal !== (e == 8'd0)) $display("FAIL free_terminal k=%0d got %b want %b", k, o_Terminal, (e == 8'd0));
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    logic [7:0] e;
    i_Enable = 1'b1; i_Mode = 2'd0; i_Down = 1'b0; i_Prescale = 4'd3;
    do_reset();
    step();
    n_checks++; if (o_Count !== 8'd0) $display("FAIL pre_entry got %0d want 0", o_Count); else n_pass++;
    for (int k = 2; k <= 30; k++) begin
      step();
      e = 8'((k - 1) / 4);
      n_checks++; if (o_Count !== e) $display("FAIL pre_count k=%0d got %0d want %0d", k, o_Count, e); else n_pass++;
    end
    i_Enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (o_Count !== 8'd7) $display("FAIL pre_pause_count got %0d want 7", o_Count); else n_pass++;
      n_checks++; if (o_Running !== 1'b0) $display("FAIL pre_pause_running got %b want 0", o_Running); else n_pass++;
    end
    i_Enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (o_Count !== 8'd7) $display("FAIL pre_resume_hold got %0d want 7", o_Count); else n_pass++;
      n_checks++; if (o_Running !== 1'b1) $display("FAIL pre_resume_running got %b want 1", o_Running); else n_pass++;
    end
    step();
    n_checks++; if (o_Count !== 8'd8) $display("FAIL pre_resume_phase got %0d want 8", o_Count); else n_pass++;
    step(); step(); step(); step();
    n_checks++; if (o_Count !== 8'd9) $display("FAIL pre_resume_next got %0d want 9", o_Count); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [7:0] e;
    i_Enable = 1'b1; i_Mode = 2'd1; i_Down = 1'b1; i_Prescale = 4'd0;
    do_reset();
    i_Load = 1'b1; i_LoadValue = 8'd5;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Count !== 8'd5) $display("FAIL os_load got %0d want 5", o_Count); else n_pass++;
    n_checks++; if (o_Running !== 1'b1) $display("FAIL os_load_running got %b want 1", o_Running); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      step();
      e = 8'(5 - k);
      n_checks++; if (o_Count !== e) $display("FAIL os_count k=%0d got %0d want %0d", k, o_Count, e); else n_pass++;
      n_checks++; if (o_Terminal !== 1'b0) $display("FAIL os_early_term k=%0d got %b want 0", k, o_Terminal); else n_pass++;
    end
    step();
    n_checks++; if (o_Count !== 8'd0) $display("FAIL os_hold got %0d want 0", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b1) $display("FAIL os_term got %b want 1", o_Terminal); else n_pass++;
    n_checks++; if (o_Running !== 1'b0) $display("FAIL os_done_running got %b want 0", o_Running); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      i_Enable = (k >= 2);
      step();
      n_checks++; if (o_Count !== 8'd0) $display("FAIL os_done_count k=%0d got %0d want 0", k, o_Count); else n_pass++;
      n_checks++; if (o_Terminal !== 1'b0) $display("FAIL os_done_term k=%0d got %b want 0", k, o_Terminal); else n_pass++;
      n_checks++; if (o_Running !== 1'b0) $display("FAIL os_done_run k=%0d got %b want 0", k, o_Running); else n_pass++;
    end
    i_Load = 1'b1; i_LoadValue = 8'd2;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Count !== 8'd2) $display("FAIL os_reload got %0d want 2", o_Count); else n_pass++;
    n_checks++; if (o_Running !== 1'b1) $display("FAIL os_reload_running got %b want 1", o_Running); else n_pass++;
    step();
    n_checks++; if (o_Count !== 8'd1) $display("FAIL os_restart got %0d want 1", o_Count); else n_pass++;
    step(); step();
    n_checks++; if (o_Terminal !== 1'b1) $display("FAIL os_restart_term got %b want 1", o_Terminal); else n_pass++;
  endtask

  task automatic test_reload();
    logic [7:0] e;
    logic [7:0] exp_cnt [9] = '{8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd253, 8'd254, 8'd255, 8'd253};
    logic       exp_trm [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    i_Enable = 1'b1; i_Mode = 2'd2; i_Down = 1'b0; i_Prescale = 4'd0;
    do_reset();
    i_Load = 1'b1; i_LoadValue = 8'd250;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Count !== 8'd250) $display("FAIL rl_load got %0d want 250", o_Count); else n_pass++;
    for (int k = 2; k <= 13; k++) begin
      step();
      e = 8'(250 + ((k - 1) % 6));
      n_checks++; if (o_Count !== e) $display("FAIL rl_count k=%0d got %0d want %0d", k, o_Count, e); else n_pass++;
      n_checks++;
      if (o_Terminal !== ((k - 1) % 6 == 0)) $display("FAIL rl_term k=%0d got %b want %b", k, o_Terminal, ((k - 1) % 6 == 0));
      else n_pass++;
    end
    i_LoadValue = 8'd253;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++; if (o_Count !== exp_cnt[k]) $display("FAIL rl2_count k=%0d got %0d want %0d", k, o_Count, exp_cnt[k]); else n_pass++;
      n_checks++; if (o_Terminal !== exp_trm[k]) $display("FAIL rl2_term k=%0d got %b want %b", k, o_Terminal, exp_trm[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    i_Enable = 1'b1; i_Mode = 2'd3; i_Down = 1'b0; i_Prescale = 4'd0;
    do_reset();
    i_Load = 1'b1; i_LoadValue = 8'd254;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Count !== 8'd254) $display("FAIL b2b_load got %0d want 254", o_Count); else n_pass++;
    step(); step();
    n_checks++; if (o_Count !== 8'd0) $display("FAIL rsvd_wrap got %0d want 0", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b1) $display("FAIL rsvd_term got %b want 1", o_Terminal); else n_pass++;
    n_checks++; if (o_Running !== 1'b1) $display("FAIL rsvd_running got %b want 1", o_Running); else n_pass++;
    i_Mode = 2'd0; i_Down = 1'b1;
    step();
    n_checks++; if (o_Count !== 8'd255) $display("FAIL down_wrap got %0d want 255", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b1) $display("FAIL down_wrap_term got %b want 1", o_Terminal); else n_pass++;
    i_Down = 1'b0; i_Load = 1'b1; i_LoadValue = 8'd100;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Count !== 8'd100) $display("FAIL load_vs_tick got %0d want 100", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b0) $display("FAIL load_vs_tick_term got %b want 0", o_Terminal); else n_pass++;
    step();
    n_checks++; if (o_Count !== 8'd101) $display("FAIL after_load got %0d want 101", o_Count); else n_pass++;
    i_Load = 1'b1; i_LoadValue = 8'd255;
    step();
    i_Load = 1'b0; i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    n_checks++; if (o_Count !== 8'd0) $display("FAIL midrun_reset_count got %0d want 0", o_Count); else n_pass++;
    n_checks++; if (o_Terminal !== 1'b0) $display("FAIL midrun_reset_term got %b want 0", o_Terminal); else n_pass++;
    n_checks++; if (o_Running !== 1'b0) $display("FAIL midrun_reset_running got %b want 0", o_Running); else n_pass++;
    i_Enable = 1'b0;
    step();
    n_checks++; if (o_Running !== 1'b0) $display("FAIL idle_stays got %b want 0", o_Running); else n_pass++;
  endtask

  task automatic test_pwm();
    int highs;
    i_Enable = 1'b1; i_Mode = 2'd0; i_Down = 1'b0; i_Prescale = 4'd0; i_Compare = 8'd64;
    do_reset();
    step();
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (o_Pwm === 1'b1) highs++;
    end
    n_checks++; if (highs !== 64) $display("FAIL pwm64_duty got %0d want 64", highs); else n_pass++;
    i_Load = 1'b1; i_LoadValue = 8'd63;
    step();
    n_checks++; if (o_Pwm !== 1'b1) $display("FAIL pwm_at63 got %b want 1", o_Pwm); else n_pass++;
    i_LoadValue = 8'd64;
    step();
    i_Load = 1'b0;
    n_checks++; if (o_Pwm !== 1'b0) $display("FAIL pwm_at64 got %b want 0", o_Pwm); else n_pass++;
    i_Compare = 8'd0;
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (o_Pwm === 1'b1) highs++;
    end
    n_checks++; if (highs !== 0) $display("FAIL pwm0_duty got %0d want 0", highs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_oneshot();
    test_reload();
    test_back_to_back();
    test_pwm();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
